// File: rtl/neuron_mac_sekvencer.sv
// Time-multiplexed MAC sequencer for one ANN neuron: walks N_IN sign-magnitude weights
// through a shared multiplier, folds in the bias and registers the sigmoid LUT result.
module neuron_mac_sekvencer #(
  parameter int unsigned    N_IN     = 60,
  parameter int unsigned    SW       = 16,
  parameter int unsigned    AW       = 22,
  parameter logic [AW-1:0]  BIAS_MAG = 22'h02_6444,
  parameter bit             BIAS_NEG = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N_IN*SW-1:0]   uzorak,
  output logic                 busy,
  output logic                 done,
  output logic [5:0]           w_addr,
  input  logic [SW-1:0]        w_data,
  output logic [SW-1:0]        mul_weight,
  output logic [SW-1:0]        mul_sample,
  input  logic [SW-1:0]        mul_product,
  output logic [AW-1:0]        suma,
  output logic                 predznak,
  input  logic [SW-1:0]        vjerojatnost,
  output logic [SW-1:0]        izlaz
);

  localparam int unsigned DW = AW + 2;

  typedef enum logic [2:0] {IDLE, PRIME, MAC, BIAS, ACT} state_t;

  state_t               state, state_nx;
  logic [N_IN*SW-1:0]   sample_q;
  logic [5:0]           idx;
  logic [AW-1:0]        p_acc, n_acc;
  logic [SW-1:0]        w_hold;
  logic                 last;
  logic signed [DW-1:0] d_sum;
  logic [DW-1:0]        d_abs;

  assign last = (idx == 6'(N_IN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = PRIME;
      PRIME:   state_nx = MAC;
      MAC:     if (last) state_nx = BIAS;
      BIAS:    state_nx = ACT;
      ACT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operands follow the ROM only during MAC; otherwise they replay the last pair used.
  assign mul_weight = (state == MAC) ? w_data : w_hold;
  assign mul_sample = sample_q[SW*idx +: SW];

  always_comb begin
    d_sum = $signed({2'b00, p_acc}) - $signed({2'b00, n_acc});
    if (BIAS_NEG) d_sum = d_sum - $signed({2'b00, BIAS_MAG});
    else          d_sum = d_sum + $signed({2'b00, BIAS_MAG});
    d_abs = d_sum[DW-1] ? DW'(-d_sum) : DW'(d_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      w_addr   <= '0;
      suma     <= '0;
      predznak <= 1'b0;
      izlaz    <= '0;
      p_acc    <= '0;
      n_acc    <= '0;
      idx      <= '0;
      sample_q <= '0;
      w_hold   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sample_q <= uzorak;
            p_acc    <= '0;
            n_acc    <= '0;
            w_addr   <= '0;
            busy     <= 1'b1;
          end
        end
        PRIME: begin
          w_addr <= 6'd1;
          idx    <= '0;
        end
        MAC: begin
          w_hold <= w_data;
          if (w_data[SW-1]) n_acc <= n_acc + AW'(mul_product);
          else              p_acc <= p_acc + AW'(mul_product);
          w_addr <= idx + 6'd2;
          if (!last) idx <= idx + 6'd1;
        end
        BIAS: begin
          predznak <= d_sum[DW-1];
          suma     <= (|d_abs[DW-1:AW]) ? '1 : d_abs[AW-1:0];
        end
        ACT: begin
          izlaz <= vjerojatnost;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
